// File: rtl/peripheral_tl_pkg.sv
// Shared TL-UL definitions for the peripheral DMA arbiter: default widths,
// opcodes, channel payload structs and arbiter lock states.
package peripheral_tl_pkg;

  localparam int unsigned TLP_AW    = 32;
  localparam int unsigned TLP_DW    = 32;
  localparam int unsigned TLP_SRCW  = 8;
  localparam int unsigned TLP_SINKW = 1;
  localparam int unsigned TLP_DBW   = TLP_DW >> 3;
  localparam int unsigned TLP_SZW   = $clog2($clog2(TLP_DBW) + 1);

  typedef enum logic [2:0] {
    PUT_FULL_DATA    = 3'h0,
    PUT_PARTIAL_DATA = 3'h1,
    GET              = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'h0,
    ACCESS_ACK_DATA = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [TLP_SZW-1:0]  size;
    logic [TLP_SRCW-1:0] source;
    logic [TLP_AW-1:0]   address;
    logic [TLP_DBW-1:0]  mask;
    logic [TLP_DW-1:0]   data;
    logic                corrupt;
  } tl_a_chan_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [TLP_SZW-1:0]   size;
    logic [TLP_SRCW-1:0]  source;
    logic [TLP_SINKW-1:0] sink;
    logic                 denied;
    logic [TLP_DW-1:0]    data;
    logic                 corrupt;
  } tl_d_chan_t;

  // Open: round-robin picks freely. Locked: a stalled beat holds the grant.
  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/peripheral_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
module peripheral_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest request wins last.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = ptr;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + (N - 1 - k)) % N;
      if (req[idx]) begin
        gnt_oh      = '0;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = IW'(idx);
        gnt_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_arbiter_tl.sv
// N-to-1 TL-UL arbiter for DMA channel masters: round-robin A channel with
// source tagging, D channel routed back by source tag, per-master credits.
module peripheral_arbiter_tl
  import peripheral_tl_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned TL_AW    = TLP_AW,
  parameter int unsigned TL_DW    = TLP_DW,
  parameter int unsigned TL_SRCW  = TLP_SRCW,
  parameter int unsigned TL_SINKW = TLP_SINKW,
  parameter int unsigned TL_DBW   = TL_DW >> 3,
  parameter int unsigned TL_SZW   = $clog2($clog2(TL_DBW) + 1),
  parameter int unsigned IW       = $clog2(N),
  parameter int unsigned USRCW    = TL_SRCW - IW,
  parameter int unsigned MAX_OS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [N*3-1:0]        m_a_opcode,
  input  logic [N*3-1:0]        m_a_param,
  input  logic [N*TL_SZW-1:0]   m_a_size,
  input  logic [N*USRCW-1:0]    m_a_source,
  input  logic [N*TL_AW-1:0]    m_a_address,
  input  logic [N*TL_DBW-1:0]   m_a_mask,
  input  logic [N*TL_DW-1:0]    m_a_data,
  input  logic [N-1:0]          m_a_corrupt,
  input  logic [N-1:0]          m_a_valid,
  output logic [N-1:0]          m_a_ready,

  output logic [N*3-1:0]        m_d_opcode,
  output logic [N*3-1:0]        m_d_param,
  output logic [N*TL_SZW-1:0]   m_d_size,
  output logic [N*USRCW-1:0]    m_d_source,
  output logic [N*TL_SINKW-1:0] m_d_sink,
  output logic [N-1:0]          m_d_denied,
  output logic [N-1:0]          m_d_corrupt,
  output logic [N-1:0]          m_d_valid,
  output logic [N*TL_DW-1:0]    m_d_data,
  input  logic [N-1:0]          m_d_ready,

  output logic [2:0]            a_opcode,
  output logic [2:0]            a_param,
  output logic [TL_SZW-1:0]     a_size,
  output logic [TL_SRCW-1:0]    a_source,
  output logic [TL_AW-1:0]      a_address,
  output logic [TL_DBW-1:0]     a_mask,
  output logic [TL_DW-1:0]      a_data,
  output logic                  a_corrupt,
  output logic                  a_valid,
  input  logic                  a_ready,

  input  logic [2:0]            d_opcode,
  input  logic [2:0]            d_param,
  input  logic [TL_SZW-1:0]     d_size,
  input  logic [TL_SRCW-1:0]    d_source,
  input  logic [TL_SINKW-1:0]   d_sink,
  input  logic                  d_denied,
  input  logic                  d_corrupt,
  input  logic                  d_valid,
  input  logic [TL_DW-1:0]      d_data,
  output logic                  d_ready,

  output logic                  err_unexp_d
);

  localparam int unsigned CW = $clog2(MAX_OS + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [IW-1:0] ptr_q;
  logic [CW-1:0] os_cnt_q [N];
  logic          err_q;

  logic [N-1:0]  eligible;
  logic [N-1:0]  arb_oh;
  logic [IW-1:0] arb_idx;
  logic          arb_any;
  logic [IW-1:0] grant;
  logic [N-1:0]  grant_oh;
  logic          valid_sel;
  logic          a_fire;
  int unsigned   sel;

  logic [IW-1:0] d_idx;
  logic          d_idx_ok;
  logic          d_fire;
  logic          d_unexp;
  logic [N-1:0]  d_dec;

  // A requester at its credit limit drops out of arbitration.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N; i++) begin
      eligible[i] = m_a_valid[i] && (os_cnt_q[i] < CW'(MAX_OS));
    end
  end

  peripheral_rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_OPEN;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Grant selection and lock: a beat stalled by a_ready keeps its grant.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    grant      = arb_idx;
    grant_oh   = arb_oh;
    valid_sel  = arb_any;
    case (state_q)
      ARB_LOCKED: begin
        grant                = lock_idx_q;
        grant_oh             = '0;
        grant_oh[lock_idx_q] = 1'b1;
        valid_sel            = m_a_valid[lock_idx_q];
      end
      default: ;
    endcase
    a_valid = reset && valid_sel;
    if (a_valid && !a_ready) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = grant;
    end else begin
      state_d    = ARB_OPEN;
    end
  end

  assign a_fire    = a_valid && a_ready;
  assign m_a_ready = grant_oh & {N{a_fire}};

  always_comb begin
    sel       = 32'(grant);
    a_opcode  = m_a_opcode[sel*3 +: 3];
    a_param   = m_a_param[sel*3 +: 3];
    a_size    = m_a_size[sel*TL_SZW +: TL_SZW];
    a_source  = {grant, m_a_source[sel*USRCW +: USRCW]};
    a_address = m_a_address[sel*TL_AW +: TL_AW];
    a_mask    = m_a_mask[sel*TL_DBW +: TL_DBW];
    a_data    = m_a_data[sel*TL_DW +: TL_DW];
    a_corrupt = m_a_corrupt[grant];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (a_fire) begin
      ptr_q <= IW'(rr_next(32'(grant), N));
    end
  end

  // D channel: tag bits pick the lane; out-of-range tags are sunk and flagged.
  assign d_idx    = d_source[TL_SRCW-1 -: IW];
  assign d_idx_ok = 32'(d_idx) < N;

  always_comb begin
    m_d_valid = '0;
    d_ready   = 1'b0;
    if (reset) begin
      if (d_idx_ok) begin
        m_d_valid[d_idx] = d_valid;
        d_ready          = m_d_ready[d_idx];
      end else begin
        d_ready          = 1'b1;
      end
    end
  end

  assign m_d_opcode  = {N{d_opcode}};
  assign m_d_param   = {N{d_param}};
  assign m_d_size    = {N{d_size}};
  assign m_d_source  = {N{d_source[USRCW-1:0]}};
  assign m_d_sink    = {N{d_sink}};
  assign m_d_denied  = {N{d_denied}};
  assign m_d_corrupt = {N{d_corrupt}};
  assign m_d_data    = {N{d_data}};

  assign d_fire  = d_valid && d_ready;
  assign d_unexp = d_fire && (!d_idx_ok || (os_cnt_q[d_idx] == '0));

  always_comb begin
    d_dec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      d_dec[i] = m_d_valid[i] && m_d_ready[i] && (os_cnt_q[i] != '0);
    end
  end

  // Credits: A fire adds, D fire removes, both together cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        os_cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      err_q <= d_unexp;
      for (int unsigned i = 0; i < N; i++) begin
        if (m_a_ready[i] && !d_dec[i]) begin
          os_cnt_q[i] <= os_cnt_q[i] + CW'(1);
        end else if (!m_a_ready[i] && d_dec[i]) begin
          os_cnt_q[i] <= os_cnt_q[i] - CW'(1);
        end
      end
    end
  end

  assign err_unexp_d = err_q;

endmodule

// File: tb/tb_peripheral_arbiter_tl.sv
// Bench for peripheral_arbiter_tl: hand-derived vector table, reset corner
// cases and randomized traffic against a transaction-level reference model.
module tb_peripheral_arbiter_tl;

  localparam int N      = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SRCW   = 8;
  localparam int SINKW  = 1;
  localparam int DBW    = 4;
  localparam int SZW    = 2;
  localparam int USRCW  = 6;
  localparam int MAX_OS = 4;

  logic                 clk;
  logic                 reset;
  logic [N*3-1:0]       m_a_opcode, m_a_param;
  logic [N*SZW-1:0]     m_a_size;
  logic [N*USRCW-1:0]   m_a_source;
  logic [N*AW-1:0]      m_a_address;
  logic [N*DBW-1:0]     m_a_mask;
  logic [N*DW-1:0]      m_a_data;
  logic [N-1:0]         m_a_corrupt, m_a_valid, m_a_ready;
  logic [N*3-1:0]       m_d_opcode, m_d_param;
  logic [N*SZW-1:0]     m_d_size;
  logic [N*USRCW-1:0]   m_d_source;
  logic [N*SINKW-1:0]   m_d_sink;
  logic [N-1:0]         m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
  logic [N*DW-1:0]      m_d_data;
  logic [2:0]           a_opcode, a_param;
  logic [SZW-1:0]       a_size;
  logic [SRCW-1:0]      a_source;
  logic [AW-1:0]        a_address;
  logic [DBW-1:0]       a_mask;
  logic [DW-1:0]        a_data;
  logic                 a_corrupt, a_valid, a_ready;
  logic [2:0]           d_opcode, d_param;
  logic [SZW-1:0]       d_size;
  logic [SRCW-1:0]      d_source;
  logic [SINKW-1:0]     d_sink;
  logic                 d_denied, d_corrupt, d_valid, d_ready;
  logic [DW-1:0]        d_data;
  logic                 err_unexp_d;

  peripheral_arbiter_tl dut (
    .clk(clk), .reset(reset),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
    .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
    .m_a_data(m_a_data), .m_a_corrupt(m_a_corrupt), .m_a_valid(m_a_valid),
    .m_a_ready(m_a_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
    .m_d_source(m_d_source), .m_d_sink(m_d_sink), .m_d_denied(m_d_denied),
    .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid), .m_d_data(m_d_data),
    .m_d_ready(m_d_ready),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied), .d_corrupt(d_corrupt), .d_valid(d_valid),
    .d_data(d_data), .d_ready(d_ready),
    .err_unexp_d(err_unexp_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: round-robin pointer, held grant, credits in flight.
  int md_ptr;
  bit md_lock;
  int md_lidx;
  int md_os [N];
  bit md_err;

  task automatic model_reset();
    md_ptr  = 0;
    md_lock = 1'b0;
    md_lidx = 0;
    md_err  = 1'b0;
    for (int i = 0; i < N; i++) md_os[i] = 0;
  endtask

  function automatic int model_pick();
    if (md_lock) return md_lidx;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (md_ptr + k) % N;
      if (m_a_valid[c] && md_os[c] < MAX_OS) return c;
    end
    return -1;
  endfunction

  function automatic bit model_av();
    if (md_lock) return m_a_valid[md_lidx];
    return model_pick() >= 0;
  endfunction

  task automatic check_model();
    int g;
    int j;
    bit av;
    logic [31:0] exp_mar;
    logic [31:0] exp_mdv;
    g  = model_pick();
    av = reset && model_av();
    j  = int'(d_source[7:6]);
    chk("a_valid", 32'(a_valid), 32'(av));
    if (av) begin
      chk("a_source",  32'(a_source),  32'({2'(g), m_a_source[g*USRCW +: USRCW]}));
      chk("a_address", a_address,      m_a_address[g*AW +: AW]);
      chk("a_data",    a_data,         m_a_data[g*DW +: DW]);
      chk("a_ctrl",    32'({a_opcode, a_param, a_size, a_mask, a_corrupt}),
          32'({m_a_opcode[g*3 +: 3], m_a_param[g*3 +: 3], m_a_size[g*SZW +: SZW],
               m_a_mask[g*DBW +: DBW], m_a_corrupt[g]}));
    end
    exp_mar = (av && a_ready) ? (32'(1) << g) : 32'(0);
    chk("m_a_ready", 32'(m_a_ready), exp_mar);
    exp_mdv = (reset && d_valid) ? (32'(1) << j) : 32'(0);
    chk("m_d_valid", 32'(m_d_valid), exp_mdv);
    chk("d_ready", 32'(d_ready), 32'(reset && m_d_ready[j]));
    chk("m_d_source", 32'(m_d_source[j*USRCW +: USRCW]), 32'(d_source[5:0]));
    chk("m_d_data", m_d_data[j*DW +: DW], d_data);
    chk("m_d_ctrl0", 32'({m_d_opcode[2:0], m_d_param[2:0], m_d_size[SZW-1:0], m_d_sink[0],
                          m_d_denied[0], m_d_corrupt[0]}),
        32'({d_opcode, d_param, d_size, d_sink, d_denied, d_corrupt}));
    chk("err_unexp_d", 32'(err_unexp_d), 32'(md_err));
  endtask

  task automatic model_update();
    int g;
    int j;
    int pre_j;
    bit av;
    bit af;
    bit df;
    g     = model_pick();
    av    = model_av();
    j     = int'(d_source[7:6]);
    af    = av && a_ready;
    df    = d_valid && m_d_ready[j];
    pre_j = md_os[j];
    md_err = df && (pre_j == 0);
    if (af) md_os[g]++;
    if (df && pre_j > 0) md_os[j]--;
    md_lock = av && !a_ready;
    if (md_lock) md_lidx = g;
    if (af) md_ptr = (g + 1) % N;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < N; i++) begin
      m_a_opcode[i*3 +: 3]         = 3'($urandom());
      m_a_param[i*3 +: 3]          = 3'($urandom());
      m_a_size[i*SZW +: SZW]       = 2'($urandom());
      m_a_source[i*USRCW +: USRCW] = 6'($urandom());
      m_a_address[i*AW +: AW]      = $urandom();
      m_a_mask[i*DBW +: DBW]       = 4'($urandom());
      m_a_data[i*DW +: DW]         = $urandom();
    end
    m_a_corrupt = 4'($urandom());
    d_opcode    = 3'($urandom());
    d_param     = 3'($urandom());
    d_size      = 2'($urandom());
    d_sink      = 1'($urandom());
    d_denied    = 1'($urandom());
    d_corrupt   = 1'($urandom());
    d_data      = $urandom();
  endtask

  task automatic drive(input logic [3:0] mav, input bit ar, input bit dv,
                       input logic [7:0] ds, input logic [3:0] mdr);
    m_a_valid = mav;
    a_ready   = ar;
    d_valid   = dv;
    d_source  = ds;
    m_d_ready = mdr;
  endtask

  task automatic run_cycle(input logic [3:0] mav, input bit ar, input bit dv,
                           input logic [7:0] ds, input logic [3:0] mdr);
    randomize_payload();
    drive(mav, ar, dv, ds, mdr);
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Outputs must be quiet while reset is held, even with every input active.
  task automatic do_reset();
    reset = 1'b0;
    drive(4'hF, 1'b1, 1'b1, 8'h00, 4'hF);
    @(negedge clk);
    chk("rst a_valid",     32'(a_valid),     32'(0));
    chk("rst m_a_ready",   32'(m_a_ready),   32'(0));
    chk("rst d_ready",     32'(d_ready),     32'(0));
    chk("rst m_d_valid",   32'(m_d_valid),   32'(0));
    chk("rst err_unexp_d", 32'(err_unexp_d), 32'(0));
    reset = 1'b1;
    model_reset();
    drive(4'h0, 1'b0, 1'b0, 8'h00, 4'h0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  mav;
    bit          ar;
    bit          dv;
    logic [7:0]  ds;
    logic [3:0]  mdr;
    bit          e_av;
    int          e_g;
    logic [3:0]  e_mar;
    logic [3:0]  e_mdv;
    bit          e_dr;
    bit          e_err;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [3:0] mav, bit ar, bit dv, logic [7:0] ds,
                              logic [3:0] mdr, bit e_av, int e_g, logic [3:0] e_mar,
                              logic [3:0] e_mdv, bit e_dr, bit e_err);
    vec_t v;
    v.rst = rst; v.mav = mav; v.ar = ar; v.dv = dv; v.ds = ds; v.mdr = mdr;
    v.e_av = e_av; v.e_g = e_g; v.e_mar = e_mar; v.e_mdv = e_mdv;
    v.e_dr = e_dr; v.e_err = e_err;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    reset = 1'b0;
    randomize_payload();
    drive(4'h0, 1'b0, 1'b0, 8'h00, 4'h0);
    model_reset();

    //               rst  mav    ar  dv  ds     mdr    av  g   mar    mdv    dr  err
    // round robin over four busy requesters, pointer wraps back to 0
    vecs.push_back(mk(1, 4'hF, 1, 0, 8'h00, 4'h0, 1,  0, 4'h1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 0, 8'h00, 4'h0, 1,  1, 4'h2, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 0, 8'h00, 4'h0, 1,  2, 4'h4, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 0, 8'h00, 4'h0, 1,  3, 4'h8, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 0, 8'h00, 4'h0, 1,  0, 4'h1, 4'h0, 0, 0));
    // requester 2 stalled, requester 0 joins; grant held, then moves to 0
    vecs.push_back(mk(0, 4'h4, 0, 0, 8'h00, 4'h0, 1,  2, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h5, 0, 0, 8'h00, 4'h0, 1,  2, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h5, 0, 0, 8'h00, 4'h0, 1,  2, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h5, 1, 0, 8'h00, 4'h0, 1,  2, 4'h4, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h1, 1, 0, 8'h00, 4'h0, 1,  0, 4'h1, 4'h0, 0, 0));
    // requester 1 uses all credits, is skipped, then freed by one response
    vecs.push_back(mk(1, 4'h2, 1, 0, 8'h00, 4'h0, 1,  1, 4'h2, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h2, 1, 0, 8'h00, 4'h0, 1,  1, 4'h2, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h2, 1, 0, 8'h00, 4'h0, 1,  1, 4'h2, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h2, 1, 0, 8'h00, 4'h0, 1,  1, 4'h2, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hA, 1, 0, 8'h00, 4'h0, 1,  3, 4'h8, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h2, 0, 1, 8'h41, 4'h2, 0, -1, 4'h0, 4'h2, 1, 0));
    vecs.push_back(mk(0, 4'h2, 1, 0, 8'h00, 4'h0, 1,  1, 4'h2, 4'h0, 0, 0));
    // simultaneous A and D fire on requester 0 leaves its count at 2
    vecs.push_back(mk(1, 4'h1, 1, 0, 8'h00, 4'h0, 1,  0, 4'h1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h1, 1, 0, 8'h00, 4'h0, 1,  0, 4'h1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h1, 1, 1, 8'h00, 4'h1, 1,  0, 4'h1, 4'h1, 1, 0));
    vecs.push_back(mk(0, 4'h1, 1, 0, 8'h00, 4'h0, 1,  0, 4'h1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h1, 1, 0, 8'h00, 4'h0, 1,  0, 4'h1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h1, 1, 0, 8'h00, 4'h0, 0, -1, 4'h0, 4'h0, 0, 0));
    // response for idle requester 3: forwarded, error pulse, count stays 0
    vecs.push_back(mk(1, 4'h0, 0, 1, 8'hC5, 4'h8, 0, -1, 4'h0, 4'h8, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 0, 8'h00, 4'h0, 0, -1, 4'h0, 4'h0, 0, 1));
    vecs.push_back(mk(0, 4'h8, 1, 0, 8'h00, 4'h0, 1,  3, 4'h8, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 8'hC0, 4'h8, 0, -1, 4'h0, 4'h8, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 0, 8'h00, 4'h0, 0, -1, 4'h0, 4'h0, 0, 0));

    for (int r = 0; r < vecs.size(); r++) begin
      vec_t v;
      v = vecs[r];
      if (v.rst) do_reset();
      randomize_payload();
      drive(v.mav, v.ar, v.dv, v.ds, v.mdr);
      @(negedge clk);
      check_model();
      chk($sformatf("row%0d a_valid", r), 32'(a_valid), 32'(v.e_av));
      if (v.e_g >= 0) chk($sformatf("row%0d grant", r), 32'(a_source[7:6]), 32'(v.e_g));
      chk($sformatf("row%0d m_a_ready", r), 32'(m_a_ready), 32'(v.e_mar));
      chk($sformatf("row%0d m_d_valid", r), 32'(m_d_valid), 32'(v.e_mdv));
      chk($sformatf("row%0d d_ready", r), 32'(d_ready), 32'(v.e_dr));
      chk($sformatf("row%0d err", r), 32'(err_unexp_d), 32'(v.e_err));
      if (v.ds == 8'h41 && v.dv)
        chk("row m_d_source lane1", 32'(m_d_source[USRCW +: USRCW]), 32'(6'h01));
      @(posedge clk);
      model_update();
      #1;
    end

    // asynchronous reset with credits at 3 and a locked beat
    do_reset();
    repeat (3) run_cycle(4'h2, 1'b1, 1'b0, 8'h00, 4'h0);
    run_cycle(4'h2, 1'b0, 1'b0, 8'h00, 4'h0);
    drive(4'h2, 1'b0, 1'b0, 8'h00, 4'h0);
    @(negedge clk);
    check_model();
    #2;
    reset = 1'b0;
    drive(4'hF, 1'b1, 1'b1, 8'h40, 4'hF);
    #1;
    chk("async rst a_valid",   32'(a_valid),   32'(0));
    chk("async rst m_a_ready", 32'(m_a_ready), 32'(0));
    chk("async rst d_ready",   32'(d_ready),   32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(4'hF, 1'b1, 1'b0, 8'h00, 4'h0);
    #1;
    chk("restart a_valid", 32'(a_valid), 32'(1));
    chk("restart grant",   32'(a_source[7:6]), 32'(0));
    check_model();
    @(posedge clk);
    model_update();
    #1;
    // requester 1 gets its full four credits back, then is held
    repeat (4) run_cycle(4'h2, 1'b1, 1'b0, 8'h00, 4'h0);
    drive(4'h2, 1'b1, 1'b0, 8'h00, 4'h0);
    @(negedge clk);
    chk("post-reset credits held", 32'(a_valid), 32'(0));
    @(posedge clk);
    model_update();
    #1;

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      run_cycle(4'($urandom()), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                8'($urandom()), ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_arbiter_tl.md
Name: peripheral_arbiter_tl

Overview:
- N-to-1 TileLink-UL arbiter that lets N DMA channel masters share one TL-UL master port towards memory or peripherals.
- Channel A: round-robin arbitration; the requester index is prepended to the source ID.
- Channel D: responses are routed back to the requester using the top bits of d_source.
- Per-requester outstanding-transaction credit counters throttle each master.
- Sits between the DMA channel engines and the TL interconnect/slave.

Parameters:
- N, 4, number of requesters (≥2).
- TL_AW, 32, address width.
- TL_DW, 32, data width.
- TL_SRCW, 8, downstream source width.
- TL_SINKW, 1, sink width.
- TL_DBW, TL_DW>>3, mask width.
- TL_SZW, $clog2($clog2(TL_DBW)+1), size width.
- IW, $clog2(N), index bits prepended to the source ID.
- USRCW, TL_SRCW-IW, upstream source width.
- MAX_OS, 4, maximum outstanding requests per requester (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- m_a_opcode/m_a_param  in  N×3  per-requester A opcode/param.
- m_a_size  in  N×TL_SZW.
- m_a_source  in  N×USRCW.
- m_a_address  in  N×TL_AW.
- m_a_mask  in  N×TL_DBW.
- m_a_data  in  N×TL_DW.
- m_a_corrupt, m_a_valid  in  N.
- m_a_ready  out  N.
- m_d_opcode/m_d_param  out  N×3.
- m_d_size  out  N×TL_SZW.
- m_d_source  out  N×USRCW.
- m_d_sink  out  N×TL_SINKW.
- m_d_denied, m_d_corrupt, m_d_valid  out  N.
- m_d_data  out  N×TL_DW.
- m_d_ready  in  N.
- a_opcode/a_param  out  3.
- a_size  out  TL_SZW.
- a_source  out  TL_SRCW.
- a_address  out  TL_AW.
- a_mask  out  TL_DBW.
- a_data  out  TL_DW.
- a_corrupt, a_valid  out  1.
- a_ready  in  1.
- d_opcode/d_param  in  3.
- d_size  in  TL_SZW.
- d_source  in  TL_SRCW.
- d_sink  in  TL_SINKW.
- d_denied, d_corrupt, d_valid  in  1.
- d_data  in  TL_DW.
- d_ready  out  1.
- err_unexp_d  out  1  one-cycle pulse on a D response for a requester with zero outstanding requests.

Behaviour:
- Reset values (while reset is low):
  - ptr=0, lock=0, lock_idx=0, all os_cnt=0, err_unexp_d=0.
  - a_valid=0, d_ready=0, all m_a_ready=0, all m_d_valid=0.
- Eligibility: eligible[i] = m_a_valid[i] && os_cnt[i]<MAX_OS.
- Arbitration (combinational, 0-cycle latency A path):
  - When lock=0, grant = first eligible index searching ptr, ptr+1, … mod N.
  - When lock=1, grant = lock_idx.
- Channel A outputs:
  - a_valid = eligible[grant] (or m_a_valid[lock_idx] while locked).
  - All a_* fields are muxed from the grant; a_source = {grant[IW-1:0], m_a_source[grant]}.
  - m_a_ready[grant] = a_ready; all other m_a_ready=0.
- Lock:
  - Set to 1 with lock_idx=grant when a_valid && !a_ready, so a presented beat is never switched while valid.
  - Cleared on A fire.
- Pointer: on A fire (a_valid && a_ready) with grant g, ptr <= (g+1) mod N. Otherwise unchanged.
- Channel D routing:
  - Index j = d_source[TL_SRCW-1:USRCW].
  - m_d_valid[j] = d_valid; all other m_d_valid=0.
  - d_ready = m_d_ready[j].
  - All m_d_* data fields are broadcast to every requester.
  - m_d_source[*] = d_source[USRCW-1:0].
  - j ≥ N (N not a power of 2): d_ready=1, response dropped, err_unexp_d pulses.
- Credit counters (os_cnt[i], width $clog2(MAX_OS+1)):
  - +1 on A fire for i.
  - −1 on D fire for i.
  - Both in the same cycle: unchanged.
  - D fire with os_cnt=0: counter stays 0 and err_unexp_d pulses the next cycle (registered).
  - Counters cannot exceed MAX_OS because a full requester is ineligible.
- Full credit while locked: the beat is already presented, so it completes.
- Single-beat TL-UL only: every A fire counts as one transaction and every D fire as one response.
- Reset mid-operation: all state clears immediately. Responses returning after reset are forwarded normally and flagged through err_unexp_d.

Decomposition:
- Shared package peripheral_tl_pkg:
  - TL opcode constants (PutFullData=0, PutPartialData=1, Get=4, AccessAck=0, AccessAckData=1).
  - typedefs tl_a_chan_t and tl_d_chan_t.
- Sub-module peripheral_rr_arbiter: N-bit request vector plus ptr in, one-hot and binary grant out, purely combinational; instantiated once.
- Credit counters and lock live in the top level.

Test Plan:
- N=4, all four requesters valid with a_ready=1 for 4 cycles -> grants 0,1,2,3 in order; a_source top bits 0,1,2,3; ptr returns to 0.
- Requester 2 valid, a_ready=0 for 3 cycles, requester 0 asserts valid in cycle 2 -> grant stays 2 with fields stable; after a_ready=1, the next grant is 0.
- Requester 1 issues 4 Gets with no D response (MAX_OS=4) -> the 5th is held (m_a_ready[1]=0) while requester 3 is still granted; one D with d_source=8'h41 -> m_d_valid[1]=1, m_d_source=6'h01, and requester 1 is eligible again.
- Same-cycle A fire and D fire for requester 0 with os_cnt=2 -> os_cnt stays 2.
- D response with d_source top bits=3 while os_cnt[3]=0 -> forwarded to requester 3; err_unexp_d=1 for one cycle; os_cnt[3] stays 0.
- reset asserted low with counters at 3 and lock=1 -> all counters 0 and a_valid=0 immediately; after release, arbitration restarts from index 0.
